// File: rtl/accel_pkg.sv
// Shared accelerator constants and the drain controller state encoding.
// Imported by the requant drain controller and its datapath.
package accel_pkg;

  localparam int N_ELEM    = 4;
  localparam int ACC_WIDTH = 32;
  localparam int ACT_WIDTH = 8;
  localparam int ADDR_W    = 8;
  localparam int SHIFT_W   = 5;
  localparam int INT8_MAX  = 127;
  localparam int INT8_MIN  = -128;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_OUT,
    S_FIN
  } state_t;

endpackage

// File: rtl/requant_drain_ctrl_if.sv
// Accumulator read port and output row write port of the drain controller.
// The master side is the controller; the slave side is the buffer pair.
interface requant_drain_ctrl_if #(
  parameter int N_ELEM    = 4,
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8,
  parameter int ADDR_W    = 8
) ();

  logic                          acc_rd_en;
  logic [ADDR_W-1:0]             acc_rd_addr;
  logic [N_ELEM*IN_WIDTH-1:0]    acc_rd_data;
  logic                          out_valid;
  logic                          out_ready;
  logic [ADDR_W-1:0]             out_addr;
  logic [N_ELEM*OUT_WIDTH-1:0]   out_data;

  modport master (
    output acc_rd_en,
    output acc_rd_addr,
    input  acc_rd_data,
    output out_valid,
    output out_addr,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  acc_rd_en,
    input  acc_rd_addr,
    output acc_rd_data,
    input  out_valid,
    input  out_addr,
    input  out_data,
    output out_ready
  );

endinterface

// File: rtl/requant_drain_ctrl_requantize.sv
// Combinational row requantizer: arithmetic shift then clamp to int8.
// Saturation is flagged when the full-width shifted value leaves int8 range.
module requant_drain_ctrl_requantize #(
  parameter int N_ELEM    = 4,
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8
) (
  input  logic [N_ELEM*IN_WIDTH-1:0]  i_data,
  input  logic [4:0]                  i_shift,
  output logic [N_ELEM*OUT_WIDTH-1:0] o_data,
  output logic                        o_sat
);
  import accel_pkg::*;

  localparam logic signed [IN_WIDTH-1:0] MAXV = IN_WIDTH'(INT8_MAX);
  localparam logic signed [IN_WIDTH-1:0] MINV = IN_WIDTH'(INT8_MIN);

  logic [N_ELEM-1:0] w_sat;

  for (genvar i = 0; i < N_ELEM; i++) begin : g_el
    logic signed [IN_WIDTH-1:0] w_x;
    logic signed [IN_WIDTH-1:0] w_sh;
    logic                       w_hi;
    logic                       w_lo;

    assign w_x  = i_data[i*IN_WIDTH +: IN_WIDTH];
    assign w_sh = w_x >>> i_shift;
    assign w_hi = w_sh > MAXV;
    assign w_lo = w_sh < MINV;
    assign w_sat[i] = w_hi | w_lo;
    assign o_data[i*OUT_WIDTH +: OUT_WIDTH] =
      w_hi ? MAXV[OUT_WIDTH-1:0] :
      w_lo ? MINV[OUT_WIDTH-1:0] :
             w_sh[OUT_WIDTH-1:0];
  end

  assign o_sat = |w_sat;

endmodule

// File: rtl/requant_drain_ctrl.sv
// Drains accumulator rows, requantizes them to int8 and writes them out.
// One row per read/capture/output pass; the output handshake paces the drain.
module requant_drain_ctrl #(
  parameter int N_ELEM    = accel_pkg::N_ELEM,
  parameter int IN_WIDTH  = accel_pkg::ACC_WIDTH,
  parameter int OUT_WIDTH = accel_pkg::ACT_WIDTH,
  parameter int ADDR_W    = accel_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] num_rows,
  input  logic [ADDR_W-1:0] acc_base,
  input  logic [ADDR_W-1:0] out_base,
  input  logic [4:0]        shift_amount,
  output logic              busy,
  output logic              done,
  output logic              sat_any,
  requant_drain_ctrl_if.master bus
);
  import accel_pkg::*;

  state_t                      r_state;
  state_t                      w_next;
  logic [ADDR_W-1:0]           r_num_rows;
  logic [ADDR_W-1:0]           r_acc_base;
  logic [ADDR_W-1:0]           r_out_base;
  logic [4:0]                  r_shift;
  logic [ADDR_W-1:0]           r_row;
  logic [N_ELEM*OUT_WIDTH-1:0] r_out_data;
  logic                        r_sat;
  logic [N_ELEM*OUT_WIDTH-1:0] w_q;
  logic                        w_sat;
  logic                        w_go;
  logic                        w_cap;
  logic                        w_adv;
  logic                        w_last;

  requant_drain_ctrl_requantize #(
    .N_ELEM    (N_ELEM),
    .IN_WIDTH  (IN_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_rq (
    .i_data  (bus.acc_rd_data),
    .i_shift (r_shift),
    .o_data  (w_q),
    .o_sat   (w_sat)
  );

  assign w_go   = (r_state == S_IDLE) && start;
  assign w_cap  = (r_state == S_CAP);
  assign w_adv  = (r_state == S_OUT) && bus.out_ready;
  assign w_last = (r_row == r_num_rows - 1'b1);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (start) w_next = (num_rows == '0) ? S_FIN : S_RD;
      S_RD:   w_next = S_CAP;
      S_CAP:  w_next = S_OUT;
      S_OUT:  if (bus.out_ready) w_next = w_last ? S_FIN : S_RD;
      S_FIN:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.acc_rd_en = 1'b0;
    bus.out_valid = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    unique case (r_state)
      S_IDLE: busy          = 1'b0;
      S_RD:   bus.acc_rd_en = 1'b1;
      S_OUT:  bus.out_valid = 1'b1;
      S_FIN:  done          = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_num_rows <= '0;
      r_acc_base <= '0;
      r_out_base <= '0;
      r_shift    <= '0;
      r_row      <= '0;
      r_out_data <= '0;
      r_sat      <= 1'b0;
    end else begin
      unique case (1'b1)
        w_go: begin
          r_num_rows <= num_rows;
          r_acc_base <= acc_base;
          r_out_base <= out_base;
          r_shift    <= shift_amount;
          r_row      <= '0;
          r_sat      <= 1'b0;
        end
        w_cap: begin
          r_out_data <= w_q;
          r_sat      <= r_sat | w_sat;
        end
        w_adv: r_row <= r_row + 1'b1;
        default: ;
      endcase
    end
  end

  // Addresses wrap modulo 2^ADDR_W by construction of the adder width.
  assign bus.acc_rd_addr = r_acc_base + r_row;
  assign bus.out_addr    = r_out_base + r_row;
  assign bus.out_data    = r_out_data;
  assign sat_any         = r_sat;

endmodule
